uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data bits per frame.
REQ-002 SHALL have parameter BAUDRATE, default 115200, line rate in bit/s.
REQ-003 SHALL have parameter CLK_FREQ_MHZ, default 125, clk frequency in MHz.
REQ-004 SHALL have parameter BAUDRATE_COUNT, default CLK_FREQ_MHZ*1_000_000/(BAUDRATE*16) (=67), clocks per oversample tick; overridable.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port en  input  1  transmitter enable; gates frame acceptance only.
REQ-008 SHALL have port start  input  1  transmit request, sampled each clk.
REQ-009 SHALL have port data_i  input  DATA_WIDTH  byte to send, captured on acceptance.
REQ-010 SHALL have port tx  output  1  serial line, registered, idle high.
REQ-011 SHALL have port tx_busy  output  1  high while a frame is in progress.
REQ-012 SHALL have port tx_done  output  1  one-cycle pulse at frame completion.

Function
REQ-013 SHALL implement FSM IDLE, START, DATA, STOP; frame = 1 start bit (0), DATA_WIDTH data bits LSB first, 1 stop bit (1); no parity.
REQ-014 SHALL accept a frame in cycle N iff state==IDLE and start==1 and en==1; data_i captured into a shift register in that cycle.
REQ-015 SHALL enter START at N+1 with tx=0 and tx_busy=1 from N+1.
REQ-016 SHALL hold each bit for exactly T=16*BAUDRATE_COUNT clocks; tick counter cleared on acceptance so the first bit is full length.
REQ-017 SHALL drive data bit k during cycles N+1+T*(k+1) .. N+T*(k+2); stop bit during N+1+T*(DATA_WIDTH+1) .. N+T*(DATA_WIDTH+2).
REQ-018 SHALL return to IDLE at N+1+T*(DATA_WIDTH+2) with tx=1, tx_busy=0 and tx_done=1 for that single cycle.
REQ-019 SHALL allow back-to-back: start accepted in the tx_done cycle yields next start bit one cycle later (one idle-high cycle gap).
REQ-020 SHALL ignore start while not IDLE; no queuing, data_i changes mid-frame have no effect.
REQ-021 SHALL complete an in-progress frame when en falls mid-frame.
REQ-022 SHALL size tick counter as $clog2(BAUDRATE_COUNT) bits and bit-phase counter as 4 bits (0..15), bit index as $clog2(DATA_WIDTH) bits; counters wrap to 0 at terminal count, never overflow.
REQ-023 SHALL hold tick and phase counters at 0 in IDLE.

Reset
REQ-024 SHALL on rst=1 at a clk edge force state IDLE, tx=1, tx_busy=0, tx_done=0, all counters and shift register 0, from the next cycle.
REQ-025 SHALL abort a frame on rst mid-operation; tx returns high the cycle after rst, no tx_done pulse.
REQ-026 SHALL ignore start in any cycle where rst=1.

Structure
REQ-027 SHALL place state encoding (IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11) and default baud parameters in shared package uart_pkg, common with the receiver.
REQ-028 SHALL instantiate one sub-module uart_baud_gen producing the oversample tick and 16th-tick bit strobe, with a synchronous clear input.

Verification (BAUDRATE_COUNT=4, T=64)
REQ-029 SHALL check: en=1, start pulse with data_i=8'hA5 at N -> tx=0 over N+1..N+64, then bits 1,0,1,0,0,1,0,1 each 64 cycles, stop high, tx_done at N+641.
REQ-030 SHALL check: en=0, start=1 with 8'h3C -> tx stays 1, tx_busy stays 0, no tx_done.
REQ-031 SHALL check: start held high continuously with 8'h00 then 8'hFF -> two frames separated by exactly one idle-high cycle, second carries 8'hFF.
REQ-032 SHALL check: start pulses while busy, data_i changed mid-frame -> single frame with original byte, no extra frame.
REQ-033 SHALL check: rst=1 during data bit 3 -> next cycle tx=1, tx_busy=0, tx_done never pulses; new start afterwards sends full correct frame.
REQ-034 SHALL check: default parameters, data 8'h55 -> each bit exactly 1072 clocks, total frame 10720 clocks.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default baud parameters,
// common to the transmitter and receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } uart_state_e;

  localparam int unsigned DEFAULT_BAUDRATE     = 115200;
  localparam int unsigned DEFAULT_CLK_FREQ_MHZ = 125;
  localparam int unsigned OVERSAMPLE           = 16;

  function automatic int unsigned baud_count(input int unsigned clk_mhz,
                                             input int unsigned baud);
    return (clk_mhz * 1_000_000) / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: one tick every BAUDRATE_COUNT clocks and a bit
// strobe on every 16th tick; synchronous clear holds both counters at zero.
module uart_baud_gen #(
  parameter int unsigned BAUDRATE_COUNT = 67
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick,
  output logic bit_strobe
);

  localparam int unsigned TW = (BAUDRATE_COUNT > 1) ? $clog2(BAUDRATE_COUNT) : 1;

  logic [TW-1:0] tick_cnt;
  logic [3:0]    phase;

  assign tick       = (tick_cnt == TW'(BAUDRATE_COUNT - 1));
  assign bit_strobe = tick && (phase == 4'd15);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      tick_cnt <= '0;
      phase    <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
      phase    <= phase + 4'd1;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 1 start bit, DATA_WIDTH data bits LSB first, 1 stop bit,
// each bit held for 16*BAUDRATE_COUNT clocks.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned BAUDRATE       = DEFAULT_BAUDRATE,
  parameter int unsigned CLK_FREQ_MHZ   = DEFAULT_CLK_FREQ_MHZ,
  parameter int unsigned BAUDRATE_COUNT = baud_count(CLK_FREQ_MHZ, BAUDRATE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  tx,
  output logic                  tx_busy,
  output logic                  tx_done
);

  localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  uart_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]         idx_q, idx_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;
  logic                  accept, tick, bit_strobe, step;

  // Counters are held clear throughout IDLE, so the start bit is full length.
  uart_baud_gen #(
    .BAUDRATE_COUNT(BAUDRATE_COUNT)
  ) u_baud_gen (
    .clk       (clk),
    .rst       (rst),
    .clr       (state_q == IDLE),
    .tick      (tick),
    .bit_strobe(bit_strobe)
  );

  assign step   = tick & bit_strobe;
  assign accept = (state_q == IDLE) && start && en;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (accept) begin
          state_d = START;
          shift_d = data_i;
          idx_d   = '0;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (step) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (step) begin
          if (idx_q == BW'(DATA_WIDTH - 1)) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            idx_d   = idx_q + BW'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_d[0];
          end
        end
      end
      STOP: begin
        if (step) begin
          state_d = IDLE;
          tx_d    = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign tx      = tx_q;
  assign tx_busy = (state_q != IDLE);
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a fast instance (BAUDRATE_COUNT=4) for the
// functional scenarios and a default-parameter instance for bit timing.
module tb_uart_tx;

  localparam int unsigned BC    = 4;
  localparam int unsigned T     = 16 * BC;
  localparam int unsigned FRAME = T * 10;
  localparam int unsigned T_DEF = 1072;

  logic       clk = 1'b0;
  logic       rst, en, start;
  logic [7:0] data_i;
  logic       tx, tx_busy, tx_done;

  logic       start_def;
  logic [7:0] data_def;
  logic       tx_def, tx_busy_def, tx_done_def;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx #(
    .DATA_WIDTH    (8),
    .BAUDRATE_COUNT(BC)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .start  (start),
    .data_i (data_i),
    .tx     (tx),
    .tx_busy(tx_busy),
    .tx_done(tx_done)
  );

  uart_tx dut_def (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .start  (start_def),
    .data_i (data_def),
    .tx     (tx_def),
    .tx_busy(tx_busy_def),
    .tx_done(tx_done_def)
  );

  // Line level for bit slot idx of a frame: 0 start, 1..8 data LSB first, 9 stop.
  function automatic logic frame_bit(input logic [7:0] d, input int unsigned idx);
    if (idx == 0) return 1'b0;
    else if (idx <= 8) return d[idx-1];
    else return 1'b1;
  endfunction

  task automatic kick(input logic [7:0] d);
    @(negedge clk);
    en     = 1'b1;
    start  = 1'b1;
    data_i = d;
  endtask

  // Checks every cycle of a frame accepted on the preceding edge, then the done cycle.
  task automatic expect_frame(input logic [7:0] d, input bit keep_start,
                              input logic [7:0] next_data, input bit noise);
    for (int t = 1; t <= int'(FRAME); t++) begin
      @(negedge clk);
      if (t == 1) begin
        start  = keep_start;
        data_i = next_data;
      end
      if (noise) begin
        if (t < int'(FRAME) - 2) begin
          start  = ($urandom_range(0, 3) == 0);
          data_i = 8'($urandom);
          en     = 1'($urandom);
        end else begin
          start  = keep_start;
          en     = 1'b1;
          data_i = next_data;
        end
      end
      checks++;
      if ({tx, tx_busy, tx_done} !== {frame_bit(d, (t - 1) / T), 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL frame_%02h t=%0d: tx/busy/done=%b%b%b expected %b10",
                 d, t, tx, tx_busy, tx_done, frame_bit(d, (t - 1) / T));
      end
    end
    @(negedge clk);
    checks++;
    if ({tx, tx_busy, tx_done} !== 3'b101) begin
      errors++;
      $display("FAIL done_%02h: tx/busy/done=%b%b%b expected 101", d, tx, tx_busy, tx_done);
    end
  endtask

  task automatic expect_idle(input string name, input int unsigned cycles);
    for (int i = 0; i < int'(cycles); i++) begin
      @(negedge clk);
      checks++;
      if ({tx, tx_busy, tx_done} !== 3'b100) begin
        errors++;
        $display("FAIL %s cycle %0d: tx/busy/done=%b%b%b expected 100",
                 name, i, tx, tx_busy, tx_done);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; start = 1'b0; data_i = '0;
    start_def = 1'b0; data_def = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx, tx_busy, tx_done} !== 3'b100) begin
      errors++;
      $display("FAIL reset_state: tx/busy/done=%b%b%b expected 100", tx, tx_busy, tx_done);
    end
    rst = 1'b0;
    expect_idle("post_reset", 2);
  endtask

  task automatic test_basic;
    kick(8'hA5);
    expect_frame(8'hA5, 1'b0, 8'h00, 1'b0);
    expect_idle("after_A5", 4);
  endtask

  task automatic test_disabled;
    @(negedge clk);
    en = 1'b0; start = 1'b1; data_i = 8'h3C;
    expect_idle("disabled", FRAME + 20);
    start = 1'b0; en = 1'b1;
  endtask

  task automatic test_back_to_back;
    kick(8'h00);
    expect_frame(8'h00, 1'b1, 8'hFF, 1'b0);
    expect_frame(8'hFF, 1'b0, 8'h00, 1'b0);
    expect_idle("after_b2b", 4);
  endtask

  task automatic test_busy_ignored;
    logic [7:0] d;
    d = 8'($urandom);
    kick(d);
    expect_frame(d, 1'b0, ~d, 1'b1);
    expect_idle("after_noise", 8);
  endtask

  task automatic test_random;
    logic [7:0] d;
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom);
      kick(d);
      expect_frame(d, 1'b0, 8'($urandom), 1'($urandom));
      expect_idle("after_random", 2);
    end
  endtask

  task automatic test_rst_mid;
    logic [7:0] d;
    d = 8'($urandom);
    kick(d);
    for (int t = 1; t <= int'(4 * T + 10); t++) begin
      @(negedge clk);
      if (t == 1) start = 1'b0;
      checks++;
      if ({tx, tx_busy} !== {frame_bit(d, (t - 1) / T), 1'b1}) begin
        errors++;
        $display("FAIL partial_%02h t=%0d: tx/busy=%b%b expected %b1",
                 d, t, tx, tx_busy, frame_bit(d, (t - 1) / T));
      end
    end
    rst = 1'b1; start = 1'b1; data_i = ~d;
    @(negedge clk);
    checks++;
    if ({tx, tx_busy, tx_done} !== 3'b100) begin
      errors++;
      $display("FAIL rst_abort: tx/busy/done=%b%b%b expected 100", tx, tx_busy, tx_done);
    end
    rst = 1'b0; start = 1'b0;
    expect_idle("after_abort", FRAME);
    d = 8'($urandom);
    kick(d);
    expect_frame(d, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_default;
    logic last;
    int   run;
    @(negedge clk);
    start_def = 1'b1; data_def = 8'h55;
    last = 1'b1; run = 0;
    for (int t = 1; t <= int'(10 * T_DEF); t++) begin
      @(negedge clk);
      if (t == 1) start_def = 1'b0;
      checks++;
      if ({tx_def, tx_busy_def, tx_done_def} !== {frame_bit(8'h55, (t - 1) / T_DEF), 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL default_frame t=%0d: tx/busy/done=%b%b%b", t, tx_def, tx_busy_def, tx_done_def);
      end
      if (t > 1 && tx_def !== last) begin
        checks++;
        if (run != int'(T_DEF)) begin
          errors++;
          $display("FAIL default_bit_len t=%0d: %0d clocks, expected %0d", t, run, T_DEF);
        end
        run = 0;
      end
      last = tx_def;
      run++;
    end
    @(negedge clk);
    checks++;
    if ({tx_def, tx_busy_def, tx_done_def} !== 3'b101) begin
      errors++;
      $display("FAIL default_done: tx/busy/done=%b%b%b expected 101", tx_def, tx_busy_def, tx_done_def);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_disabled;
    test_back_to_back;
    test_busy_ignored;
    test_random;
    test_rst_mid;
    test_default;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
